// File: rtl/rtc_bus_pkg.sv
// Shared types and timing defaults for the multiplexed A/D RTC bus-cycle generator.
package rtc_bus_pkg;

  localparam int DW_DEF    = 8;
  localparam int T_SU_DEF  = 2;
  localparam int T_STB_DEF = 4;
  localparam int T_HLD_DEF = 2;
  localparam int T_GAP_DEF = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_SU,
    S_A_STB,
    S_A_HLD,
    S_GAP,
    S_D_SU,
    S_D_STB,
    S_D_HLD,
    S_RECOV
  } state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Cycle number (accept cycle counts as 1) in which done is high.
  function automatic int rtc_latency(input int t_su, input int t_stb, input int t_hld,
                                     input int t_gap, input bit skip);
    int phase;
    phase = t_su + t_stb + t_hld;
    return skip ? phase + 1 : 2 * phase + t_gap + 1;
  endfunction

endpackage

// File: rtl/rtc_bus_cycle_if.sv
// Controller handshake plus pad-side A/D bus signals of the RTC bus-cycle generator.
interface rtc_bus_cycle_if #(parameter int DW = 8);
  logic          start;
  logic          write_en;
  logic          skip_addr;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] ad_in;
  logic [DW-1:0] ad_out;
  logic          ad_oe;
  logic          cs_n;
  logic          rd_n;
  logic          wr_n;
  logic          ad_n;
  logic          busy;
  logic          done;
  logic [DW-1:0] rdata;

  modport master (
    output start, write_en, skip_addr, addr, wdata, ad_in,
    input  ad_out, ad_oe, cs_n, rd_n, wr_n, ad_n, busy, done, rdata
  );

  modport slave (
    input  start, write_en, skip_addr, addr, wdata, ad_in,
    output ad_out, ad_oe, cs_n, rd_n, wr_n, ad_n, busy, done, rdata
  );
endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module rtc_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_cycle.sv
// Bus-cycle generator for the multiplexed A/D RTC interface: optional address
// phase, gap, data phase (read or write), recovery; all pad strobes registered.
//
// state   | meaning
// IDLE    | waiting for start, bus released
// A_SU    | address driven, CS low, strobes high
// A_STB   | address latched into RTC by WR low
// A_HLD   | address held, strobes released
// GAP     | CS high between phases
// D_SU    | CS low, data driven on writes
// D_STB   | RD or WR low; read data captured on exit
// D_HLD   | data held, strobes released
// RECOV   | CS high, done on first cycle, still busy
module rtc_bus_cycle
  import rtc_bus_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int T_SU  = T_SU_DEF,
  parameter int T_STB = T_STB_DEF,
  parameter int T_HLD = T_HLD_DEF,
  parameter int T_GAP = T_GAP_DEF
) (
  input logic            clk,
  input logic            reset,
  rtc_bus_cycle_if.slave bus
);

  localparam int CW = $clog2(max4(T_SU, T_STB, T_HLD, T_GAP)) + 1;

  state_e        state_q, state_d;
  logic          write_q, skip_q;
  logic [DW-1:0] addr_q, wdata_q, rdata_q;
  logic          accept, write_m;
  logic [DW-1:0] addr_m, wdata_m;
  logic          cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, ad_n_q, ad_n_d;
  logic          ad_oe_q, ad_oe_d, busy_q, busy_d, done_q, done_d;
  logic [DW-1:0] ad_out_q, ad_out_d;
  logic          tmr_load, tmr_expired;
  logic [CW-1:0] tmr_val;

  function automatic logic [CW-1:0] phase_len(input state_e s);
    case (s)
      S_A_SU,  S_D_SU:  return CW'(T_SU - 1);
      S_A_STB, S_D_STB: return CW'(T_STB - 1);
      S_A_HLD, S_D_HLD: return CW'(T_HLD - 1);
      S_GAP,   S_RECOV: return CW'(T_GAP - 1);
      default:          return '0;
    endcase
  endfunction

  assign accept = (state_q == S_IDLE) && bus.start;

  // Outputs are decoded from the next state, so the accept edge must see the
  // live request fields rather than the copies being latched on that edge.
  assign write_m = accept ? bus.write_en : write_q;
  assign addr_m  = accept ? bus.addr     : addr_q;
  assign wdata_m = accept ? bus.wdata    : wdata_q;

  assign tmr_load = (state_d != state_q);
  assign tmr_val  = phase_len(state_d);

  rtc_phase_timer #(.W(CW)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      skip_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      ad_n_q   <= 1'b1;
      ad_oe_q  <= 1'b0;
      ad_out_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      ad_n_q   <= ad_n_d;
      ad_oe_q  <= ad_oe_d;
      ad_out_q <= ad_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      if (accept) begin
        write_q <= bus.write_en;
        skip_q  <= bus.skip_addr;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (state_q == S_D_STB && state_d != S_D_STB && !write_q) rdata_q <= bus.ad_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start)  state_d = bus.skip_addr ? S_D_SU : S_A_SU;
      S_A_SU:  if (tmr_expired) state_d = S_A_STB;
      S_A_STB: if (tmr_expired) state_d = S_A_HLD;
      S_A_HLD: if (tmr_expired) state_d = S_GAP;
      S_GAP:   if (tmr_expired) state_d = S_D_SU;
      S_D_SU:  if (tmr_expired) state_d = S_D_STB;
      S_D_STB: if (tmr_expired) state_d = S_D_HLD;
      S_D_HLD: if (tmr_expired) state_d = S_RECOV;
      S_RECOV: if (tmr_expired) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = '0;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_RECOV) && (state_q != S_RECOV);
    case (state_d)
      S_A_SU, S_A_STB, S_A_HLD: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_m;
        wr_n_d   = (state_d != S_A_STB);
      end
      S_D_SU, S_D_STB, S_D_HLD: begin
        cs_n_d  = 1'b0;
        ad_oe_d = write_m;
        if (write_m) ad_out_d = wdata_m;
        if (state_d == S_D_STB) begin
          if (write_m) wr_n_d = 1'b0;
          else         rd_n_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.cs_n   = cs_n_q;
  assign bus.rd_n   = rd_n_q;
  assign bus.wr_n   = wr_n_q;
  assign bus.ad_n   = ad_n_q;
  assign bus.ad_oe  = ad_oe_q;
  assign bus.ad_out = ad_out_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Scoreboard bench for rtc_bus_cycle: default-timing instance plus an all-ones timing instance.
module tb_rtc_bus_cycle;
  import rtc_bus_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rtc_bus_cycle_if #(.DW(8)) if1 ();
  rtc_bus_cycle_if #(.DW(8)) if2 ();

  rtc_bus_cycle #(.DW(8)) dut (.clk(clk), .reset(reset), .bus(if1));
  rtc_bus_cycle #(.DW(8), .T_SU(1), .T_STB(1), .T_HLD(1), .T_GAP(1)) dut_min (
    .clk(clk), .reset(reset), .bus(if2));

  typedef struct {
    int done_cyc, end_cyc, cs_lo, ad_lo, wr_a, wr_d, rd, oe;
    logic [7:0] addr, wdata, rdata;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   n_cmp = 0, n_mis = 0;
  int   edge_cnt = 0;
  logic [7:0] rdata_model = 8'h00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) edge_cnt++;

  // Monitor: accumulates per-transaction observations, compares at busy fall.
  bit   active = 0, prev_busy = 0;
  int   t0, m_done, m_dpulse, m_cs, m_ad, m_wra, m_wrd, m_rd, m_oe, m_bad, m_viol;
  exp_t cur;

  always @(negedge clk) begin
    if (reset) begin
      if (active && sb.size() > 0) void'(sb.pop_front());
      active    = 0;
      prev_busy = 0;
    end else begin
      if (!prev_busy && if1.busy) begin
        active = 1; t0 = edge_cnt; acc_q.push_back(t0);
        m_done = 0; m_dpulse = 0; m_cs = 0; m_ad = 0; m_wra = 0; m_wrd = 0;
        m_rd = 0; m_oe = 0; m_bad = 0; m_viol = 0;
        if (sb.size() > 0) cur = sb[0];
      end
      if (active) begin
        if (!if1.cs_n) m_cs++;
        if (!if1.ad_n) m_ad++;
        if (!if1.wr_n && !if1.ad_n) m_wra++;
        if (!if1.wr_n && if1.ad_n) m_wrd++;
        if (!if1.rd_n) m_rd++;
        if (if1.ad_oe) m_oe++;
        if (if1.ad_oe && ((!if1.ad_n && if1.ad_out !== cur.addr) ||
                          (if1.ad_n && if1.ad_out !== cur.wdata))) m_bad++;
        if ((!if1.rd_n && !if1.wr_n) || (!if1.rd_n && if1.ad_oe)) m_viol++;
        if (if1.done) begin
          m_dpulse++;
          if (m_done == 0) m_done = edge_cnt - t0 + 1;
        end
      end
      if (prev_busy && !if1.busy && active) begin
        active = 0;
        if (sb.size() == 0) chk("sb_unexpected_txn", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", m_done, e.done_cyc);
          chk("busy_low_cycle", edge_cnt - t0 + 1, e.end_cyc);
          chk("done_pulses", m_dpulse, 1);
          chk("cs_low_cycles", m_cs, e.cs_lo);
          chk("ad_low_cycles", m_ad, e.ad_lo);
          chk("wr_low_addr", m_wra, e.wr_a);
          chk("wr_low_data", m_wrd, e.wr_d);
          chk("rd_low", m_rd, e.rd);
          chk("ad_oe_cycles", m_oe, e.oe);
          chk("ad_out_value", m_bad, 0);
          chk("strobe_oe_rules", m_viol, 0);
          chk("rdata", if1.rdata, e.rdata);
        end
      end
      prev_busy = if1.busy;
    end
  end

  task automatic push_exp(input bit we, input bit sk, input logic [7:0] a,
                          input logic [7:0] wd, input logic [7:0] din);
    exp_t e;
    int   p;
    p          = T_SU_DEF + T_STB_DEF + T_HLD_DEF;
    e.done_cyc = rtc_latency(T_SU_DEF, T_STB_DEF, T_HLD_DEF, T_GAP_DEF, sk);
    e.end_cyc  = e.done_cyc + T_GAP_DEF;
    e.cs_lo    = sk ? p : 2 * p;
    e.ad_lo    = sk ? 0 : p;
    e.wr_a     = sk ? 0 : T_STB_DEF;
    e.wr_d     = we ? T_STB_DEF : 0;
    e.rd       = we ? 0 : T_STB_DEF;
    e.oe       = (sk ? 0 : p) + (we ? p : 0);
    if (!we) rdata_model = din;
    e.rdata    = rdata_model;
    e.addr     = a;
    e.wdata    = wd;
    sb.push_back(e);
  endtask

  task automatic drive(input bit we, input bit sk, input logic [7:0] a,
                       input logic [7:0] wd, input logic [7:0] din);
    @(negedge clk);
    if1.write_en = we; if1.skip_addr = sk; if1.addr = a; if1.wdata = wd;
    if1.ad_in = din; if1.start = 1'b1;
  endtask

  task automatic wait_busy(input logic val, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (if1.busy !== val && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (if1.busy !== val) chk(tag, if1.busy, val);
  endtask

  task automatic run_txn(input bit we, input bit sk, input logic [7:0] a,
                         input logic [7:0] wd, input logic [7:0] din);
    push_exp(we, sk, a, wd, din);
    drive(we, sk, a, wd, din);
    wait_busy(1'b1, 5, "accept_timeout");
    if1.start = 1'b0;
    if1.write_en = ~we; if1.skip_addr = ~sk; if1.addr = ~a; if1.wdata = ~wd;
    wait_busy(1'b0, 40, "busy_end_timeout");
  endtask

  initial begin
    int cnt, n, dc, cs, wr, rd;
    reset = 1'b1;
    {if1.start, if1.write_en, if1.skip_addr} = 3'b000;
    if1.addr = 8'h00; if1.wdata = 8'h00; if1.ad_in = 8'h00;
    {if2.start, if2.write_en, if2.skip_addr} = 3'b000;
    if2.addr = 8'h00; if2.wdata = 8'h00; if2.ad_in = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state", {if1.cs_n, if1.rd_n, if1.wr_n, if1.ad_n, if1.ad_oe, if1.busy,
                        if1.done, if1.ad_out, if1.rdata}, {4'b1111, 3'b000, 16'h0000});

    run_txn(1'b0, 1'b0, 8'h21, 8'h00, 8'h5A);
    run_txn(1'b1, 1'b0, 8'h02, 8'h37, 8'hA5);
    run_txn(1'b0, 1'b1, 8'h40, 8'h00, 8'h3C);
    run_txn(1'b1, 1'b1, 8'h13, 8'hE7, 8'h81);

    // Second start mid-transaction must be dropped.
    push_exp(1'b0, 1'b0, 8'h55, 8'h00, 8'h96);
    drive(1'b0, 1'b0, 8'h55, 8'h00, 8'h96);
    wait_busy(1'b1, 5, "accept_timeout");
    if1.start = 1'b0;
    repeat (4) @(negedge clk);
    if1.start = 1'b1; if1.addr = 8'hEE;
    @(negedge clk);
    if1.start = 1'b0; if1.addr = 8'h55;
    wait_busy(1'b0, 40, "busy_end_timeout");
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (if1.busy) cnt++;
    end
    chk("ignored_start", cnt, 0);

    // Held start: back-to-back transactions.
    push_exp(1'b0, 1'b0, 8'h0A, 8'h00, 8'h6B);
    push_exp(1'b0, 1'b0, 8'h0A, 8'h00, 8'h6B);
    drive(1'b0, 1'b0, 8'h0A, 8'h00, 8'h6B);
    wait_busy(1'b1, 5, "accept_timeout");
    wait_busy(1'b0, 40, "busy_end_timeout");
    wait_busy(1'b1, 5, "b2b_accept_timeout");
    if1.start = 1'b0;
    wait_busy(1'b0, 40, "busy_end_timeout");
    @(negedge clk);
    if (acc_q.size() >= 2)
      chk("b2b_accept_spacing", acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2],
          rtc_latency(T_SU_DEF, T_STB_DEF, T_HLD_DEF, T_GAP_DEF, 1'b0) + T_GAP_DEF);
    else chk("b2b_accept_count", acc_q.size(), 2);

    // Asynchronous reset during the read strobe.
    push_exp(1'b0, 1'b0, 8'h44, 8'h00, 8'hC3);
    drive(1'b0, 1'b0, 8'h44, 8'h00, 8'hC3);
    wait_busy(1'b1, 5, "accept_timeout");
    if1.start = 1'b0;
    n = 0;
    while (if1.rd_n !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("rd_strobe_seen", if1.rd_n, 1'b0);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", {if1.cs_n, if1.rd_n, if1.wr_n, if1.ad_n, if1.ad_oe,
                                   if1.busy, if1.done, if1.ad_out, if1.rdata},
           {4'b1111, 3'b000, 16'h0000});
    rdata_model = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_txn(1'b0, 1'b0, 8'h21, 8'h00, 8'h5A);

    // Minimum timings on the second instance.
    @(negedge clk);
    if2.addr = 8'h11; if2.ad_in = 8'h99; if2.start = 1'b1;
    n = 0;
    while (!if2.busy && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("min_accept", if2.busy, 1'b1);
    if2.start = 1'b0;
    n = 0; dc = 0; cs = 0; wr = 0; rd = 0;
    while (if2.busy && n < 20) begin
      n++;
      if (!if2.cs_n) cs++;
      if (!if2.wr_n) wr++;
      if (!if2.rd_n) rd++;
      if (if2.done && dc == 0) dc = n;
      @(negedge clk);
    end
    chk("min_done_cycle", dc, 8);
    chk("min_busy_low_cycle", n + 1, 9);
    chk("min_cs_low", cs, 6);
    chk("min_wr_width", wr, 1);
    chk("min_rd_width", rd, 1);
    chk("min_rdata", if2.rdata, 8'h99);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
